// File: rtl/sync_fifo_fwft_if.sv
// Bundle of the sync_fifo_fwft data, flag and error signals.
// The master side is the producer/consumer pair; the slave side is the FIFO.
interface sync_fifo_fwft_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [AW:0]      af_thresh;
  logic [AW:0]      ae_thresh;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      level;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, af_thresh, ae_thresh, err_clr,
    input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, af_thresh, ae_thresh, err_clr,
    output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost flags and live level. Sticky overflow/underflow exist when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_fwft_if.slave fifo_io
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full, empty, rd_ok, wr_ok;

  // Handshake: a read is taken when rd_en && !empty; a write is taken when
  // wr_en && (!full || rd_ok), so a full FIFO still accepts a write paired with a read.
  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign rd_ok = fifo_io.rd_en && !empty;
  assign wr_ok = fifo_io.wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; reset only discards it by clearing the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= fifo_io.din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign fifo_io.dout = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_ok) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign fifo_io.dout = dout_q;
    end
  endgenerate

  assign fifo_io.full         = full;
  assign fifo_io.empty        = empty;
  assign fifo_io.level        = level_q;
  assign fifo_io.almost_full  = (level_q >= fifo_io.af_thresh);
  assign fifo_io.almost_empty = (level_q <= fifo_io.ae_thresh);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the clearing cycle keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifo_io.wr_en && !wr_ok)      overflow_d = 1'b1;
    else if (fifo_io.err_clr)         overflow_d = 1'b0;
    if (fifo_io.rd_en && !rd_ok)      underflow_d = 1'b1;
    else if (fifo_io.err_clr)         underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_io.overflow  = overflow_q;
  assign fifo_io.underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr    = fifo_io.err_clr;
  assign fifo_io.overflow  = 1'b0;
  assign fifo_io.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a standard-mode and an FWFT-mode instance share one
// stimulus stream and are compared against a queue-based model of the FIFO.
module tb_sync_fifo_fwft;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = $clog2(D);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [W-1:0]  din = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW:0]   af_th = '0;
  logic [AW:0]   ae_th = '0;

  sync_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) sif ();
  sync_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) fif ();

  assign sif.wr_en = wr_en;   assign fif.wr_en = wr_en;
  assign sif.din = din;       assign fif.din = din;
  assign sif.rd_en = rd_en;   assign fif.rd_en = rd_en;
  assign sif.err_clr = err_clr; assign fif.err_clr = err_clr;
  assign sif.af_thresh = af_th; assign fif.af_thresh = af_th;
  assign sif.ae_thresh = ae_th; assign fif.ae_thresh = ae_th;

  sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst_n(rst_n), .fifo_io(sif)
  );
  sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .fifo_io(fif)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] mq[$];     // model contents, head at index 0
  logic [W-1:0] exp_q[$];  // words expected on the read side, in order
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("std_level", 32'(sif.level), 32'(n));
    chk("std_full", 32'(sif.full), 32'(n == D));
    chk("std_empty", 32'(sif.empty), 32'(n == 0));
    chk("std_afull", 32'(sif.almost_full), 32'(n >= int'(af_th)));
    chk("std_aempty", 32'(sif.almost_empty), 32'(n <= int'(ae_th)));
    chk("std_ovf", 32'(sif.overflow), 32'(m_ovf));
    chk("std_unf", 32'(sif.underflow), 32'(m_unf));
    chk("fw_level", 32'(fif.level), 32'(n));
    chk("fw_full", 32'(fif.full), 32'(n == D));
    chk("fw_empty", 32'(fif.empty), 32'(n == 0));
    chk("fw_afull", 32'(fif.almost_full), 32'(n >= int'(af_th)));
    chk("fw_aempty", 32'(fif.almost_empty), 32'(n <= int'(ae_th)));
    chk("fw_ovf", 32'(fif.overflow), 32'(m_ovf));
    chk("fw_unf", 32'(fif.underflow), 32'(m_unf));
    if (n > 0) chk("fw_head", 32'(fif.dout), 32'(mq[0]));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the falling edge, checks the state left by
  // the previous rising edge, then advances the model across the coming edge.
  task automatic cyc(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wr_en = wr; din = d; rd_en = rd; err_clr = clr;
    #1;
    check_state();
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wr && ((mq.size() < D) || rd_ok);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
    if (wr && !wr_ok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !rd_ok) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
`endif
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rd_en && !fif.empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underrun act=read exp=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("fw_dout", 32'(fif.dout), 32'(e));
          @(posedge clk);
          #1;
          chk("std_dout", 32'(sif.dout), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state, including almost_full with a zero threshold
    af_th = '0; ae_th = (AW+1)'(2);
    #1;
    check_state();
    chk("rst_std_dout", 32'(sif.dout), 32'h0);
    af_th = (AW+1)'(14);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // fill 0x01..0x10, then an extra write while full
    for (int i = 1; i <= D; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    // simultaneous read/write at full
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    // drain, then read while empty, clear-vs-set collision, clear
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // FWFT latency: write, then read on the very next cycle
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // reset mid-operation at level 9
    for (int i = 0; i < 9; i++) cyc(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_state();
    chk("midrst_std_dout", 32'(sif.dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // random traffic with moving thresholds: many pointer wraps, both boundaries
    for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      af_th = (AW+1)'($urandom_range(0, D));
      ae_th = (AW+1)'($urandom_range(0, D));
      cyc(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // drain whatever is left and settle
    for (int i = 0; i < D + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
